cas_key_loader: RTL and testbench

CAS_KEY_LOADER -- requirements
Module: cas_key_loader

---
 rtl/cas_key_loader.sv | 116 +++++++++++
 tb/tb_cas_key_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cas_key_loader.sv
// Loads a KEY_W-bit key as a little-endian byte stream followed by an XOR
// checksum byte; the key is committed to key_out only when the checksum matches.
module cas_key_loader #(
   parameter int KEY_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             busy,
   output logic             err,
   output logic [1:0]       state_dbg
);

   localparam int BEATS = KEY_W / 8;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   shadow_q, shadow_d;
   logic [7:0]         csum_q, csum_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               key_valid_q, key_valid_d;
   logic               err_q, err_d;
   logic               accept;

   // Stream handshake: a beat transfers on any cycle where s_valid && s_ready.
   // s_ready is high in LOAD and CHECK only; IDLE never accepts data.
   assign s_ready   = (state_q != IDLE);
   assign accept    = s_valid && s_ready;
   assign busy      = (state_q != IDLE);
   assign key_out   = key_q;
   assign key_valid = key_valid_q;
   assign err       = err_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      csum_d      = csum_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      err_d       = err_q;

      // start wins over any beat presented in the same cycle, in every state.
      if (start) begin
         state_d  = LOAD;
         cnt_d    = '0;
         shadow_d = '0;
         csum_d   = '0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (accept) begin
                  shadow_d[int'(cnt_q) * 8 +: 8] = s_data;
                  csum_d = csum_q ^ s_data;
                  if (cnt_q == LAST_BEAT) begin
                     state_d = CHECK;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  state_d = IDLE;
                  if (s_data == csum_q) begin
                     key_d       = shadow_q;
                     key_valid_d = 1'b1;
                     err_d       = 1'b0;
                  end else begin
                     key_d       = '0;
                     key_valid_d = 1'b0;
                     err_d       = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         csum_q      <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         csum_q      <= csum_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_cas_key_loader.sv
// Directed bench for cas_key_loader: commit results go through an expected
// queue checked by a monitor; reset/idle/restart behaviour is checked inline.
module tb_cas_key_loader;

   localparam logic [63:0] NOM_KEY = 64'h0123456789ABCDEF;
   localparam logic [63:0] ALT_KEY = 64'h0807060504030201;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic [63:0] key_out;
   logic        key_valid;
   logic        busy;
   logic        err;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // {key, key_valid, err}
   logic [65:0] exp_q[$];
   logic [65:0] exp_e;

   cas_key_loader #(.KEY_W(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .key_out   (key_out),
      .key_valid (key_valid),
      .busy      (busy),
      .err       (err),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      s_valid = 1'b1;
      s_data  = b;
      tick();
      s_valid = 1'b0;
      s_data  = 8'h00;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_key(input logic [63:0] key, input logic [7:0] cs, input int gap,
                           input bit chk_busy);
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(key[8*i +: 8], gap);
         if (chk_busy) check("busy_during_load", 64'(busy), 64'd1);
      end
      send_byte(cs, gap);
   endtask

   // Monitor: a checksum beat taken in CHECK must show its result one cycle later.
   always begin
      @(negedge clk);
      if (!rst && state_dbg == 2'd2 && s_valid && s_ready && !start) begin
         @(negedge clk);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: got key %h valid %b err %b expected none",
                     key_out, key_valid, err);
         end else begin
            checks--;
            exp_e = exp_q.pop_front();
            check("commit_key", key_out, exp_e[65:2]);
            check("commit_key_valid", 64'(key_valid), 64'(exp_e[1]));
            check("commit_err", 64'(err), 64'(exp_e[0]));
            check("commit_busy", 64'(busy), 64'd0);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      check("rst_key_out", key_out, 64'd0);
      check("rst_key_valid", 64'(key_valid), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd0);

      // Nominal back-to-back load
      exp_q.push_back({NOM_KEY, 1'b1, 1'b0});
      load_key(NOM_KEY, 8'h00, 0, 1'b0);
      tick();

      // Bad checksum, err sticky, then cleared by a good load
      exp_q.push_back({64'd0, 1'b0, 1'b1});
      load_key(NOM_KEY, 8'hFF, 0, 1'b0);
      repeat (3) tick();
      check("err_sticky", 64'(err), 64'd1);
      check("err_key_out", key_out, 64'd0);
      exp_q.push_back({NOM_KEY, 1'b1, 1'b0});
      load_key(NOM_KEY, 8'h00, 0, 1'b0);
      tick();

      // Stalls of 3 cycles between every beat
      exp_q.push_back({NOM_KEY, 1'b1, 1'b0});
      load_key(NOM_KEY, 8'h00, 3, 1'b1);
      tick();

      // Restart mid-load; old key stays visible until the new commit
      pulse_start();
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      check("restart_hold_key", key_out, NOM_KEY);
      check("restart_hold_valid", 64'(key_valid), 64'd1);
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(8'hFF, 0);
      check("check_hold_key", key_out, NOM_KEY);
      check("check_state", 64'(state_dbg), 64'd2);
      exp_q.push_back({64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0});
      send_byte(8'h00, 0);
      check("restart_new_key", key_out, 64'hFFFFFFFFFFFFFFFF);
      tick();

      // Reset after 5 accepted beats, with a beat presented on the reset edge
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(NOM_KEY[8*i +: 8], 0);
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h67;
      tick();
      rst     = 1'b0;
      s_valid = 1'b0;
      check("midrst_key_out", key_out, 64'd0);
      check("midrst_key_valid", 64'(key_valid), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_state", 64'(state_dbg), 64'd0);
      s_valid = 1'b1;
      s_data  = 8'h55;
      for (int i = 0; i < 4; i++) begin
         check("midrst_s_ready", 64'(s_ready), 64'd0);
         tick();
      end
      s_valid = 1'b0;

      // IDLE ignores s_valid without start
      exp_q.push_back({NOM_KEY, 1'b1, 1'b0});
      load_key(NOM_KEY, 8'h00, 0, 1'b0);
      s_valid = 1'b1;
      s_data  = 8'hAA;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_s_ready", 64'(s_ready), 64'd0);
      end
      s_valid = 1'b0;
      check("idle_key_out", key_out, NOM_KEY);
      check("idle_key_valid", 64'(key_valid), 64'd1);
      check("idle_err", 64'(err), 64'd0);
      check("idle_state", 64'(state_dbg), 64'd0);

      // start coinciding with the checksum beat wins; no commit
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(8'hA5, 0);
      start   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h00;
      tick();
      start   = 1'b0;
      s_valid = 1'b0;
      check("start_win_key", key_out, NOM_KEY);
      check("start_win_state", 64'(state_dbg), 64'd1);
      check("start_win_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 8; i++) send_byte(ALT_KEY[8*i +: 8], 0);
      exp_q.push_back({ALT_KEY, 1'b1, 1'b0});
      send_byte(8'h08, 0);
      check("alt_key_out", key_out, ALT_KEY);

      repeat (3) tick();
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
